data_memory_banked: RTL and testbench

DATA_MEMORY_BANKED -- requirements
Module: data_memory_banked

---
 rtl/data_memory_banked.sv | 173 +++++++++++++++++
 tb/tb_data_memory_banked.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/data_memory_banked.sv
// Banked 32-bit data memory with tag-decoded regions and a request/response handshake.
// Sub-word stores are done as read-modify-write; sub-word loads are lane-selected and extended.
module data_memory_banked #(
  parameter int          NUM_REGIONS = 2,
  parameter logic [15:0] REGION0_TAG = 16'h1000,
  parameter logic [15:0] REGION1_TAG = 16'h7fff,
  parameter logic [15:0] REGION2_TAG = 16'h2000,
  parameter logic [15:0] REGION3_TAG = 16'h3000,
  parameter int          WORDS_LOG2  = 10
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req_valid_in,
  output logic        req_ready_out,
  input  logic        we_in,
  input  logic [31:0] addr_in,
  input  logic [1:0]  size_in,
  input  logic        signed_in,
  input  logic [31:0] writedata_in,
  output logic        resp_valid_out,
  input  logic        resp_ready_in,
  output logic [31:0] readdata_out,
  output logic        error_out
);

  localparam int DEPTH   = 1 << WORDS_LOG2;
  localparam int ENTRIES = NUM_REGIONS * DEPTH;
  localparam int IW      = $clog2(ENTRIES);

  typedef enum logic [1:0] {IDLE, READ, MERGE, RESP} state_e;

  state_e                state_q;
  logic                  req_ready_q;
  logic                  resp_valid_q;
  logic                  error_q;
  logic                  we_q;
  logic [15:0]           tag_q;
  logic [WORDS_LOG2+1:0] offs_q;
  logic [1:0]            size_q;
  logic                  signed_q;
  logic [31:0]           wdata_q;
  logic [31:0]           rdata_q;
  logic [31:0]           mem_q [ENTRIES];

  logic                  hit;
  logic [1:0]            region;
  logic                  misaligned;
  logic                  fault;
  logic [IW-1:0]         idx;
  logic [31:0]           merged;
  logic [31:0]           load_data;
  logic [7:0]            byte_sel;
  logic [15:0]           half_sel;

  function automatic logic [15:0] tag_of(input int i);
    case (i)
      0:       return REGION0_TAG;
      1:       return REGION1_TAG;
      2:       return REGION2_TAG;
      default: return REGION3_TAG;
    endcase
  endfunction

  // Descending scan so the lowest-numbered matching region wins.
  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    hit    = 1'b0;
    region = 2'd0;
    for (int i = NUM_REGIONS - 1; i >= 0; i--) begin
      if (tag_q == tag_of(i)) begin
        hit    = 1'b1;
        region = 2'(i);
      end
    end
    case (size_q)
      2'b00:   misaligned = 1'b0;
      2'b01:   misaligned = offs_q[0];
      2'b11:   misaligned = |offs_q[1:0];
      default: misaligned = 1'b1;
    endcase
    fault = !hit || misaligned;
    idx   = IW'({region, offs_q[WORDS_LOG2+1:2]});
  end

  always_comb begin
    merged = rdata_q;
    case (size_q)
      2'b00:   merged[{offs_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
      2'b01:   merged[{offs_q[1], 4'b0000} +: 16] = wdata_q[15:0];
      2'b11:   merged = wdata_q;
      default: merged = rdata_q;
    endcase
  end

  always_comb begin
    byte_sel = rdata_q[{offs_q[1:0], 3'b000} +: 8];
    half_sel = rdata_q[{offs_q[1], 4'b0000} +: 16];
    case (size_q)
      2'b00:   load_data = {{24{signed_q & byte_sel[7]}}, byte_sel};
      2'b01:   load_data = {{16{signed_q & half_sel[15]}}, half_sel};
      default: load_data = rdata_q;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      req_ready_q  <= 1'b1;
      resp_valid_q <= 1'b0;
      error_q      <= 1'b0;
      we_q         <= 1'b0;
      tag_q        <= '0;
      offs_q       <= '0;
      size_q       <= '0;
      signed_q     <= 1'b0;
      wdata_q      <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req_valid_in) begin
            we_q        <= we_in;
            tag_q       <= addr_in[31:16];
            offs_q      <= addr_in[WORDS_LOG2+1:0];
            size_q      <= size_in;
            signed_q    <= signed_in;
            wdata_q     <= writedata_in;
            req_ready_q <= 1'b0;
            state_q     <= READ;
          end
        end
        READ: begin
          if (fault) begin
            error_q      <= 1'b1;
            resp_valid_q <= 1'b1;
            state_q      <= RESP;
          end else if (we_q) begin
            state_q      <= MERGE;
          end else begin
            resp_valid_q <= 1'b1;
            state_q      <= RESP;
          end
        end
        MERGE: begin
          resp_valid_q <= 1'b1;
          state_q      <= RESP;
        end
        RESP: begin
          if (resp_ready_in) begin
            resp_valid_q <= 1'b0;
            error_q      <= 1'b0;
            req_ready_q  <= 1'b1;
            state_q      <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // NOTE: the array and its read register are deliberately left out of reset; contents survive it.
  // Reset drops state_q out of MERGE asynchronously, so an interrupted store never writes.
  always_ff @(posedge clock) begin
    if (state_q == READ)  rdata_q     <= mem_q[idx];
    if (state_q == MERGE) mem_q[idx]  <= merged;
  end

  assign req_ready_out  = req_ready_q;
  assign resp_valid_out = resp_valid_q;
  assign error_out      = error_q;
  assign readdata_out   = (resp_valid_q && !error_q && !we_q) ? load_data : 32'h0;

endmodule

// File: tb/tb_data_memory_banked.sv
// Randomized bench for data_memory_banked against a byte-addressed reference model.
module tb_data_memory_banked;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        req_valid_in = 1'b0;
  logic        req_ready_out;
  logic        we_in = 1'b0;
  logic [31:0] addr_in = '0;
  logic [1:0]  size_in = '0;
  logic        signed_in = 1'b0;
  logic [31:0] writedata_in = '0;
  logic        resp_valid_out;
  logic        resp_ready_in = 1'b0;
  logic [31:0] readdata_out;
  logic        error_out;

  data_memory_banked #(.NUM_REGIONS(2), .WORDS_LOG2(10)) dut (
    .clock(clock), .reset(reset),
    .req_valid_in(req_valid_in), .req_ready_out(req_ready_out),
    .we_in(we_in), .addr_in(addr_in), .size_in(size_in), .signed_in(signed_in),
    .writedata_in(writedata_in),
    .resp_valid_out(resp_valid_out), .resp_ready_in(resp_ready_in),
    .readdata_out(readdata_out), .error_out(error_out)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;
  logic [7:0] model_bytes [int];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%08h expected=0x%08h", tag, got, exp);
    end
  endtask

  // Reference model: regions are flat byte arrays of 4 KiB, indexed by addr[11:0].
  function automatic int region_of(input logic [15:0] tag);
    if (tag == 16'h1000) return 0;
    if (tag == 16'h7fff) return 1;
    return -1;
  endfunction

  function automatic bit faults(input logic [31:0] a, input logic [1:0] sz);
    if (region_of(a[31:16]) < 0) return 1'b1;
    if (sz == 2'b10) return 1'b1;
    if (sz == 2'b01 && a[0]) return 1'b1;
    if (sz == 2'b11 && a[1:0] != 2'b00) return 1'b1;
    return 1'b0;
  endfunction

  function automatic int nbytes(input logic [1:0] sz);
    if (sz == 2'b00) return 1;
    if (sz == 2'b01) return 2;
    return 4;
  endfunction

  function automatic int key_of(input logic [31:0] a);
    return region_of(a[31:16]) * 4096 + int'({20'b0, a[11:0]});
  endfunction

  function automatic logic [31:0] model_load(input logic [31:0] a, input logic [1:0] sz, input bit sgn);
    logic [31:0] v = '0;
    int n = nbytes(sz);
    for (int k = 0; k < n; k++) v = v | (32'(model_bytes[key_of(a) + k]) << (8 * k));
    if (sgn && n < 4 && v[8 * n - 1]) v = v | (32'hFFFF_FFFF << (8 * n));
    return v;
  endfunction

  task automatic model_store(input logic [31:0] a, input logic [1:0] sz, input logic [31:0] wd);
    int n = nbytes(sz);
    for (int k = 0; k < n; k++) model_bytes[key_of(a) + k] = wd[8 * k +: 8];
  endtask

  // One full request/response; hold = cycles the response is stalled before acceptance.
  task automatic transact(input bit we, input logic [31:0] a, input logic [1:0] sz, input bit sgn,
                          input logic [31:0] wd, input int hold, output logic [31:0] got);
    bit          f = faults(a, sz);
    logic [31:0] exp_data;
    int          exp_lat;
    int          lat;
    logic        got_err;
    exp_data = (f || we) ? 32'h0 : model_load(a, sz, sgn);
    exp_lat  = (we && !f) ? 3 : 2;
    @(negedge clock);
    check($sformatf("ready_idle@%08h", a), 32'(req_ready_out), 32'd1);
    we_in = we; addr_in = a; size_in = sz; signed_in = sgn; writedata_in = wd;
    req_valid_in = 1'b1;
    @(posedge clock); #1;
    req_valid_in = 1'b0;
    we_in = 1'($urandom); addr_in = $urandom; size_in = 2'($urandom);
    signed_in = 1'($urandom); writedata_in = $urandom;
    lat = 1;
    while (!resp_valid_out && lat < 12) begin
      @(posedge clock); #1;
      lat++;
    end
    check($sformatf("latency@%08h", a), 32'(lat), 32'(exp_lat));
    check($sformatf("error@%08h", a), 32'(error_out), 32'(f));
    check($sformatf("rdata@%08h", a), readdata_out, exp_data);
    got = readdata_out;
    got_err = error_out;
    if (we && !f) model_store(a, sz, wd);
    for (int h = 0; h < hold; h++) begin
      @(negedge clock);
      req_valid_in = ~req_valid_in;
      we_in = 1'b1; addr_in = 32'h1000_0000; size_in = 2'b11; writedata_in = 32'h0;
      @(posedge clock); #1;
      check("hold_valid", 32'(resp_valid_out), 32'd1);
      check("hold_rdata", readdata_out, got);
      check("hold_error", 32'(error_out), 32'(got_err));
      check("hold_not_ready", 32'(req_ready_out), 32'd0);
    end
    @(negedge clock);
    req_valid_in = 1'b0;
    resp_ready_in = 1'b1;
    @(posedge clock); #1;
    resp_ready_in = 1'b0;
    check("back_idle_ready", 32'(req_ready_out), 32'd1);
    check("back_idle_valid", 32'(resp_valid_out), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] got;
    logic [31:0] wd;
    logic [15:0] tag;
    int          r;

    reset = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    check("rst_ready", 32'(req_ready_out), 32'd1);
    check("rst_valid", 32'(resp_valid_out), 32'd0);
    check("rst_rdata", readdata_out, 32'h0);
    check("rst_error", 32'(error_out), 32'd0);
    @(negedge clock);
    reset = 1'b0;

    // Give every word of the random pool a known value.
    for (int reg_i = 0; reg_i < 2; reg_i++) begin
      tag = (reg_i == 0) ? 16'h1000 : 16'h7fff;
      for (int w = 0; w < 8; w++) transact(1'b1, {tag, 16'(w * 4)}, 2'b11, 1'b0, $urandom, 0, got);
    end

    transact(1'b1, 32'h1000_0004, 2'b11, 1'b0, 32'hDEAD_BEEF, 0, got);
    transact(1'b0, 32'h1000_0004, 2'b11, 1'b0, 32'h0, 0, got);
    check("word_load", got, 32'hDEAD_BEEF);

    wd = $urandom;
    wd[7:0] = 8'h5A;
    transact(1'b1, 32'h1000_0006, 2'b00, 1'b0, wd, 0, got);
    transact(1'b0, 32'h1000_0006, 2'b01, 1'b1, 32'h0, 0, got);
    check("half_signed", got, 32'hFFFF_DE5A);
    transact(1'b0, 32'h1000_0006, 2'b01, 1'b0, 32'h0, 0, got);
    check("half_unsigned", got, 32'h0000_DE5A);
    transact(1'b0, 32'h1000_0007, 2'b00, 1'b1, 32'h0, 0, got);
    check("byte_signed", got, 32'hFFFF_FFDE);
    transact(1'b0, 32'h1000_0007, 2'b00, 1'b0, 32'h0, 0, got);
    check("byte_unsigned", got, 32'h0000_00DE);

    transact(1'b0, 32'h2000_0000, 2'b11, 1'b0, 32'h0, 0, got);
    transact(1'b0, 32'h1000_0002, 2'b11, 1'b0, 32'h0, 0, got);
    transact(1'b1, 32'h1000_0006, 2'b11, 1'b0, 32'h1111_1111, 0, got);
    transact(1'b1, 32'h1000_0005, 2'b01, 1'b0, 32'h2222_2222, 0, got);
    transact(1'b1, 32'h1000_0004, 2'b10, 1'b0, 32'h3333_3333, 0, got);
    transact(1'b0, 32'h1000_0004, 2'b11, 1'b0, 32'h0, 0, got);
    check("fault_no_write", got, 32'hDE5A_BEEF);

    transact(1'b1, 32'h7fff_0000, 2'b11, 1'b0, 32'h0BAD_F00D, 0, got);
    transact(1'b1, 32'h1000_0000, 2'b11, 1'b0, 32'h1234_5678, 0, got);
    transact(1'b0, 32'h7fff_0000, 2'b11, 1'b0, 32'h0, 0, got);
    check("region1_data", got, 32'h0BAD_F00D);
    transact(1'b0, 32'h1000_0000, 2'b11, 1'b0, 32'h0, 0, got);
    check("region0_data", got, 32'h1234_5678);
    transact(1'b0, 32'h1000_1000, 2'b11, 1'b0, 32'h0, 0, got);
    check("alias_wrap", got, 32'h1234_5678);

    transact(1'b0, 32'h1000_0004, 2'b11, 1'b0, 32'h0, 5, got);
    transact(1'b0, 32'h1000_0000, 2'b11, 1'b0, 32'h0, 0, got);
    check("no_stray_accept", got, 32'h1234_5678);

    // Reset in the middle of a store's MERGE cycle.
    transact(1'b1, 32'h1000_0008, 2'b11, 1'b0, 32'h1122_3344, 0, got);
    @(negedge clock);
    we_in = 1'b1; addr_in = 32'h1000_0008; size_in = 2'b11; writedata_in = 32'hCAFE_F00D;
    req_valid_in = 1'b1;
    @(posedge clock); #1;
    req_valid_in = 1'b0;
    @(posedge clock); #1;
    check("merge_busy", 32'(req_ready_out), 32'd0);
    #1;
    reset = 1'b1;
    #1;
    check("midrst_ready", 32'(req_ready_out), 32'd1);
    check("midrst_valid", 32'(resp_valid_out), 32'd0);
    check("midrst_rdata", readdata_out, 32'h0);
    check("midrst_error", 32'(error_out), 32'd0);
    @(negedge clock);
    reset = 1'b0;
    transact(1'b0, 32'h1000_0008, 2'b11, 1'b0, 32'h0, 0, got);
    check("rst_store_dropped", got, 32'h1122_3344);

    for (int t = 0; t < 80; t++) begin
      r = $urandom_range(0, 9);
      tag = (r == 0) ? 16'h2000 : (r < 5) ? 16'h1000 : 16'h7fff;
      transact(1'($urandom), {tag, 4'($urandom_range(0, 15)), 12'($urandom_range(0, 31))},
               2'($urandom_range(0, 3)), 1'($urandom), $urandom, $urandom_range(0, 2), got);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
